sha256_digest_capture: RTL and testbench

//  Receiving end of the SHA256 core's serial digest output. Samples the 16-bit hashed_data stream
//  (one halfword per cycle while read_enable is high; done marks the final word), assembles it into a
//  256-bit digest and holds it for a downstream consumer via a valid/ack handshake.

---
 rtl/sha256_pkg.sv | 22 ++
 rtl/sha256_digest_capture.sv | 128 ++++++++++++
 tb/tb_sha256_digest_capture.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA256 constants and the digest-capture state encoding, used by the
// capture block and by anything that drives or checks reference digests.
package sha256_pkg;

  localparam int SHA_DATA_W   = 16;
  localparam int SHA_DIGEST_W = 256;
  localparam int SHA_WORDS    = SHA_DIGEST_W / SHA_DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Initial hash value H0..H7 and the digest of the three-byte message "abc".
  localparam logic [SHA_DIGEST_W-1:0] SHA256_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [SHA_DIGEST_W-1:0] SHA256_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

endpackage

// File: rtl/sha256_digest_capture.sv
// Assembles the SHA256 core's serial halfword digest stream into a full digest,
// holds it behind a valid/ack handshake and flags malformed frames.
module sha256_digest_capture
  import sha256_pkg::*;
#(
  parameter  int DATA_W   = SHA_DATA_W,
  parameter  int DIGEST_W = SHA_DIGEST_W,
  localparam int WORDS    = DIGEST_W / DATA_W,
  localparam int CNT_W    = $clog2(WORDS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hash_valid,
  input  logic                hash_last,
  input  logic [DATA_W-1:0]   hashed_data,
  input  logic [DIGEST_W-1:0] expected_digest,
  input  logic                digest_ack,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  output logic                digest_match,
  output logic                frame_error,
  output logic [CNT_W:0]      word_count
);

  localparam logic [CNT_W:0] FULL_COUNT = (CNT_W+1)'(WORDS);

  state_t              state_reg;
  state_t              state_next;
  logic [CNT_W:0]      count_inc;
  logic [DIGEST_W-1:0] shifted;
  logic                frame_full;

  // word_count is always 0 in IDLE, so count_inc also covers the first word.
  assign count_inc  = word_count + 1'b1;
  assign shifted    = {digest[DIGEST_W-DATA_W-1:0], hashed_data};
  assign frame_full = (count_inc == FULL_COUNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, COLLECT: begin
        if (hash_valid) begin
          if (hash_last) begin
            state_next = frame_full ? HOLD : IDLE;
          end else if (frame_full) begin
            state_next = DRAIN;
          end else begin
            state_next = COLLECT;
          end
        end
      end
      DRAIN: begin
        if (hash_valid && hash_last) begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (digest_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    digest_valid = (state_reg == HOLD);
  end

  // Datapath follows the FSM decision so the shift, count and error updates
  // always agree with where the state is going.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digest       <= '0;
      digest_match <= 1'b0;
      frame_error  <= 1'b0;
      word_count   <= '0;
    end else begin
      case (state_reg)
        IDLE, COLLECT: begin
          if (hash_valid) begin
            digest <= shifted;
            case (state_next)
              HOLD: begin
                word_count   <= count_inc;
                digest_match <= (shifted == expected_digest);
              end
              IDLE: begin
                frame_error <= 1'b1;
                word_count  <= '0;
              end
              DRAIN: begin
                frame_error <= 1'b1;
                word_count  <= count_inc;
              end
              default: word_count <= count_inc;
            endcase
          end
        end
        DRAIN: begin
          if (hash_valid && hash_last) begin
            word_count <= '0;
          end
        end
        HOLD: begin
          // Ack wins over a colliding word; the word is still an error.
          if (hash_valid) begin
            frame_error <= 1'b1;
          end
          if (digest_ack) begin
            word_count   <= '0;
            digest_match <= 1'b0;
          end
        end
        default: word_count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_digest_capture.sv
// Directed bench: stimulus pushes expected digests into a scoreboard, a monitor
// pops and checks them on each rising digest_valid.
module tb_sha256_digest_capture;
  import sha256_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    hash_valid = 1'b0;
  logic                    hash_last = 1'b0;
  logic [SHA_DATA_W-1:0]   hashed_data = '0;
  logic [SHA_DIGEST_W-1:0] expected_digest = '0;
  logic                    digest_ack = 1'b0;
  logic [SHA_DIGEST_W-1:0] digest;
  logic                    digest_valid;
  logic                    digest_match;
  logic                    frame_error;
  logic [4:0]              word_count;

  typedef struct packed {
    logic [SHA_DIGEST_W-1:0] d;
    logic                    m;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic valid_q = 1'b0;

  sha256_digest_capture dut (
    .clock           (clock),
    .reset           (reset),
    .hash_valid      (hash_valid),
    .hash_last       (hash_last),
    .hashed_data     (hashed_data),
    .expected_digest (expected_digest),
    .digest_ack      (digest_ack),
    .digest          (digest),
    .digest_valid    (digest_valid),
    .digest_match    (digest_match),
    .frame_error     (frame_error),
    .word_count      (word_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every rising digest_valid must correspond to a queued frame.
  always @(negedge clock) begin
    if (digest_valid && !valid_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got digest %0h with no frame queued", digest);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_digest", digest, e.d);
        check("sb_match", 256'(digest_match), 256'(e.m));
      end
    end
    valid_q = digest_valid;
  end

  // Sends n words back to back; last_at is the index carrying hash_last (-1 for none).
  task automatic send_frame(input logic [255:0] val, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      hash_valid  = 1'b1;
      hash_last   = (i == last_at);
      hashed_data = (i < 16) ? val[255-16*i -: 16] : 16'(16'h0bad + i);
      @(posedge clock);
      #1;
    end
    hash_valid = 1'b0;
    hash_last  = 1'b0;
  endtask

  task automatic ack_digest(input string tag);
    @(negedge clock);
    digest_ack = 1'b1;
    @(posedge clock);
    #1;
    digest_ack = 1'b0;
    @(negedge clock);
    check({tag, "_valid_fall"}, 256'(digest_valid), 256'(0));
  endtask

  task automatic full_frame(input string tag, input logic [255:0] val,
                            input logic [255:0] xp, input logic m);
    expected_digest = xp;
    sb.push_back('{d: val, m: m});
    send_frame(val, 16, 15);
    @(negedge clock);
    check({tag, "_valid_lat1"}, 256'(digest_valid), 256'(1));
    check({tag, "_count"}, 256'(word_count), 256'(16));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [255:0] flipped;
    flipped    = SHA256_ABC;
    flipped[0] = ~flipped[0];

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_digest", digest, 256'(0));
    check("rst_valid", 256'(digest_valid), 256'(0));
    check("rst_match", 256'(digest_match), 256'(0));
    check("rst_ferr", 256'(frame_error), 256'(0));
    check("rst_count", 256'(word_count), 256'(0));

    // Reset while collecting: partial frame vanishes, nothing is presented.
    send_frame(SHA256_IV, 7, -1);
    @(negedge clock);
    check("mid_count7", 256'(word_count), 256'(7));
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_digest", digest, 256'(0));
    check("mid_rst_count", 256'(word_count), 256'(0));
    check("mid_rst_valid", 256'(digest_valid), 256'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;

    full_frame("abc", SHA256_ABC, SHA256_ABC, 1'b1);
    check("abc_ferr", 256'(frame_error), 256'(0));
    ack_digest("abc");

    full_frame("abc_bad", SHA256_ABC, flipped, 1'b0);
    ack_digest("abc_bad");
    check("abc_bad_match_clr", 256'(digest_match), 256'(0));

    // Held digest must survive words arriving while nobody acks it.
    full_frame("hold", SHA256_ABC, SHA256_ABC, 1'b1);
    check("hold_ferr_before", 256'(frame_error), 256'(0));
    for (int c = 0; c < 20; c++) begin
      hash_valid  = (c == 3 || c == 8 || c == 13);
      hash_last   = (c == 13);
      hashed_data = 16'(16'hbee0 + c);
      @(posedge clock);
      #1;
    end
    hash_valid = 1'b0;
    hash_last  = 1'b0;
    @(negedge clock);
    check("hold_digest", digest, SHA256_ABC);
    check("hold_valid", 256'(digest_valid), 256'(1));
    check("hold_match", 256'(digest_match), 256'(1));
    check("hold_ferr", 256'(frame_error), 256'(1));
    // Ack colliding with a word: ack wins, word dropped, no restart.
    digest_ack  = 1'b1;
    hash_valid  = 1'b1;
    hashed_data = 16'h1234;
    @(posedge clock);
    #1;
    digest_ack = 1'b0;
    hash_valid = 1'b0;
    @(negedge clock);
    check("collide_valid", 256'(digest_valid), 256'(0));
    check("collide_count", 256'(word_count), 256'(0));
    full_frame("b2b", SHA256_IV, SHA256_IV, 1'b1);
    ack_digest("b2b");

    // Short frame: 15 words, last on the 15th.
    pulse_reset();
    @(negedge clock);
    check("short_pre_ferr", 256'(frame_error), 256'(0));
    send_frame(SHA256_ABC, 15, 14);
    repeat (2) @(negedge clock);
    check("short_ferr", 256'(frame_error), 256'(1));
    check("short_valid", 256'(digest_valid), 256'(0));
    check("short_count", 256'(word_count), 256'(0));

    // Long frame: 17 words, last on the 17th; then a clean frame.
    pulse_reset();
    send_frame(SHA256_ABC, 16, -1);
    @(negedge clock);
    check("long_ferr", 256'(frame_error), 256'(1));
    check("long_count_sat", 256'(word_count), 256'(16));
    send_frame(SHA256_ABC, 1, 0);
    @(negedge clock);
    check("long_valid", 256'(digest_valid), 256'(0));
    check("long_count_clr", 256'(word_count), 256'(0));
    full_frame("after_long", SHA256_IV, SHA256_IV, 1'b1);
    ack_digest("after_long");

    repeat (3) @(negedge clock);
    check("sb_empty", 256'(sb.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
